widths_shift_pipe: RTL and testbench
====================================

Name: widths_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter; next generation of the combinational 8-bit shl/shr block.
- Adds WIDTH generalisation and four modes: SHL, SHR, SRA, ROL.
- Adds one logarithmic stage per register, a valid/ready handshake on both sides, and a lost-bits flag.
- Sits between operand producers and consumers in the datapath; accepts one operation per cycle.

Parameters:
- WIDTH, 8, data width; power of two, ≥ 2.
- SHW, $clog2(WIDTH), derived localparam; shift-amount width and pipeline depth. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operation valid
- in_ready  output  1  block can accept an input this cycle
- data_in  input  WIDTH  operand
- shift_amt  input  SHW  shift distance, 0..WIDTH-1
- mode  input  2  00 SHL, 01 SHR (logical), 10 SRA (arithmetic right), 11 ROL (rotate left)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- data_out  output  WIDTH  shifted result
- out_lost  output  1  1 if any 1-bit left the word (SHL/SHR/SRA); always 0 for ROL

Behaviour:
- Reset: the asynchronous assert of rst_n clears all stage valids, data, mode, amount and lost registers.
  - out_valid=0, data_out=0, out_lost=0.
  - in_ready=1 from the first cycle after deassert.
- Pipeline: SHW register stages, s=0..SHW-1.
  - Stage s conditionally shifts by 2^s per bit s of the carried shift_amt.
  - Each stage carries valid, data, mode, the remaining amount bits and an accumulated lost flag.
  - The last stage drives data_out, out_valid and out_lost directly from registers.
- Latency: a transfer accepted in cycle N has its result on the outputs in cycle N+SHW, provided there was no stall.
  - For WIDTH=8, latency is 3.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - An input transfers when in_valid && in_ready.
  - On advance, every stage loads from its predecessor; stage 0 loads the input, and its valid = in_valid.
  - When !advance, the whole pipe holds. Outputs stay stable while out_valid && !out_ready.
  - Bubbles are not squeezed; a global stall is acceptable.
- Throughput: 1 result per cycle with out_ready held at 1. Order is preserved.
- Arithmetic, per stage, shift by k=2^s when enabled:
  - SHL: zero fill from the LSB. lost |= OR of the top k bits before the shift.
  - SHR: zero fill from the MSB. lost |= OR of the low k bits.
  - SRA: fill with the original MSB, which is carried unchanged through the stages. lost |= OR of the low k bits.
  - ROL: bits wrap from the MSB to the LSB. lost unchanged (0).
- Boundaries:
  - shift_amt=0 gives data_out=data_in, out_lost=0.
  - shift_amt=WIDTH-1 is the maximum; no out-of-range encoding exists.
  - Invalid stages must still hold their data deterministically, but their contents are don't-care.
  - Only out_valid qualifies data_out and out_lost.
  - out_valid may be 1 with in_valid=0; the pipe drains normally.
- Reset mid-operation: all in-flight operations are discarded with no output. The first result after reset comes from the first post-reset transfer.
- No combinational path exists from in_valid or data_in to the outputs. The only combinational path is out_ready → in_ready.

Test Plan:
- WIDTH=8, mode=SHL, data_in=0x81, amt=1, out_ready=1 → 3 cycles later out_valid=1, data_out=0x02, out_lost=1.
- mode=SRA, data_in=0x80, amt=3 → data_out=0xF0, out_lost=0.
- Arithmetic sweep:
  - mode=SHR, 0xF0, amt=4 → 0x0F, lost=0.
  - mode=SHR, 0xF0, amt=7 → 0x01, lost=1.
  - mode=ROL, 0x81, amt=4 → 0x18, lost=0.
  - any mode with amt=0 → data unchanged, lost=0.
- Backpressure:
  - out_ready=0; stream 0x01, 0x02, 0x03 with mode=SHL, amt=1, in_valid=1 every cycle.
  - Once the first result appears, in_ready=0 and data_out holds at 0x02 across stall cycles.
  - Raise out_ready → 0x02, 0x04, 0x06 appear in order, with no loss or duplication.
- Back-to-back random stream of 1000 operations against a reference model, out_ready randomly toggled:
  - every result matches the model, in order;
  - out_valid never drops while stalled.
- Reset mid-stream:
  - assert rst_n=0 asynchronously with 3 operations in flight → out_valid=0 and data_out=0 immediately.
  - After release, only post-reset operations emerge, each with latency 3.

Source files
------------

// File: rtl/widths_shift_pipe.sv
// Pipelined logarithmic barrel shifter (SHL/SHR/SRA/ROL) with valid/ready on both sides.
// Stage s applies a 2^s shift when bit s of the carried amount is set and accumulates a lost-bits flag.
module widths_shift_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH)-1:0]   shift_amt,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_lost
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  logic             valid_q [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  mode_e            mode_q  [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic             msb_q   [SHW];
  logic             lost_q  [SHW];

  logic             valid_d [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  mode_e            mode_d  [SHW];
  logic [SHW-1:0]   amt_d   [SHW];
  logic             msb_d   [SHW];
  logic             lost_d  [SHW];

  logic             src_valid_s [SHW];
  logic [WIDTH-1:0] src_data_s  [SHW];
  mode_e            src_mode_s  [SHW];
  logic [SHW-1:0]   src_amt_s   [SHW];
  logic             src_msb_s   [SHW];
  logic             src_lost_s  [SHW];
  logic [WIDTH-1:0] shifted_s   [SHW];
  logic             stage_lost_s[SHW];

  logic advance_s;

  // A full pipe only moves when the consumer takes the result; otherwise everything holds.
  assign advance_s = !valid_q[SHW-1] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_q[SHW-1];
  assign data_out  = data_q[SHW-1];
  assign out_lost  = lost_q[SHW-1];

  // Select each stage's source: the input port for stage 0, the previous stage register otherwise.
  always_comb begin
    src_valid_s[0] = in_valid;
    src_data_s[0]  = data_in;
    src_mode_s[0]  = mode_e'(mode);
    src_amt_s[0]   = shift_amt;
    src_msb_s[0]   = data_in[WIDTH-1];
    src_lost_s[0]  = 1'b0;
    for (int s = 1; s < SHW; s++) begin
      src_valid_s[s] = valid_q[s-1];
      src_data_s[s]  = data_q[s-1];
      src_mode_s[s]  = mode_q[s-1];
      src_amt_s[s]   = amt_q[s-1];
      src_msb_s[s]   = msb_q[s-1];
      src_lost_s[s]  = lost_q[s-1];
    end
  end

  // Per-stage shift by 2^s; SRA fills from the operand's original MSB carried alongside the data.
  always_comb begin
    for (int s = 0; s < SHW; s++) begin
      shifted_s[s]    = src_data_s[s];
      stage_lost_s[s] = 1'b0;
      case (src_mode_s[s])
        MODE_SHL: begin
          shifted_s[s]    = src_data_s[s] << (1 << s);
          stage_lost_s[s] = |(src_data_s[s] & ~(ONES >> (1 << s)));
        end
        MODE_SHR: begin
          shifted_s[s]    = src_data_s[s] >> (1 << s);
          stage_lost_s[s] = |(src_data_s[s] & ~(ONES << (1 << s)));
        end
        MODE_SRA: begin
          shifted_s[s]    = (src_data_s[s] >> (1 << s)) |
                            (src_msb_s[s] ? ~(ONES >> (1 << s)) : ZEROS);
          stage_lost_s[s] = |(src_data_s[s] & ~(ONES << (1 << s)));
        end
        MODE_ROL: begin
          shifted_s[s]    = (src_data_s[s] << (1 << s)) |
                            (src_data_s[s] >> (WIDTH - (1 << s)));
          stage_lost_s[s] = 1'b0;
        end
        default: begin
          shifted_s[s]    = src_data_s[s];
          stage_lost_s[s] = 1'b0;
        end
      endcase

      valid_d[s] = src_valid_s[s];
      mode_d[s]  = src_mode_s[s];
      amt_d[s]   = src_amt_s[s];
      msb_d[s]   = src_msb_s[s];
      if (src_amt_s[s][s]) begin
        data_d[s] = shifted_s[s];
        lost_d[s] = src_lost_s[s] | stage_lost_s[s];
      end else begin
        data_d[s] = src_data_s[s];
        lost_d[s] = src_lost_s[s];
      end
    end
  end

  // Stage registers: cleared on reset, loaded together on advance, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SHW; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= ZEROS;
        mode_q[s]  <= MODE_SHL;
        amt_q[s]   <= {SHW{1'b0}};
        msb_q[s]   <= 1'b0;
        lost_q[s]  <= 1'b0;
      end
    end else if (advance_s) begin
      for (int s = 0; s < SHW; s++) begin
        valid_q[s] <= valid_d[s];
        data_q[s]  <= data_d[s];
        mode_q[s]  <= mode_d[s];
        amt_q[s]   <= amt_d[s];
        msb_q[s]   <= msb_d[s];
        lost_q[s]  <= lost_d[s];
      end
    end
  end

endmodule

// File: tb/tb_widths_shift_pipe.sv
// Bench for widths_shift_pipe (WIDTH=8): directed cases, backpressure, random stream against an
// arithmetic reference model, and reset in the middle of a stream.
module tb_widths_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [2:0] shift_amt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       out_lost;

  int tests = 0;
  int fails = 0;
  int popped = 0;
  int n_acc = 0;
  logic       stalled = 1'b0;
  logic [8:0] held = 9'd0;
  logic [8:0] exp_q[$];

  widths_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_amt(shift_amt), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_lost(out_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Whole-amount reference: {lost, result} computed directly from the operand with integer math.
  function automatic logic [8:0] ref_shift(input logic [1:0] m, input logic [7:0] d, input logic [2:0] a);
    int v;
    int ai;
    int r;
    logic lost;
    v = int'(d);
    ai = int'(a);
    r = v;
    lost = 1'b0;
    case (m)
      2'd0: begin r = (v << ai) & 255; lost = ((v >> (8 - ai)) != 0); end
      2'd1: begin r = v >> ai; lost = ((v % (1 << ai)) != 0); end
      2'd2: begin
        r = v >> ai;
        if (v >= 128) r = r | ((255 << (8 - ai)) & 255);
        lost = ((v % (1 << ai)) != 0);
      end
      default: begin r = ((v << ai) | (v >> (8 - ai))) & 255; lost = 1'b0; end
    endcase
    return {lost, r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with scoreboard bookkeeping; entered and left at a falling edge.
  task automatic cyc();
    logic [8:0] e;
    #1;
    if (stalled) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'({out_lost, data_out}), 32'(held));
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 32'({out_lost, data_out}), 32'(e));
        popped++;
      end
    end
    stalled = out_valid && !out_ready;
    held = {out_lost, data_out};
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_shift(mode, data_in, shift_amt));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single isolated operation with latency measurement; pipe must be empty on entry.
  task automatic run_one(input string tag, input logic [1:0] m, input logic [7:0] d,
                         input logic [2:0] a, input logic [7:0] ed, input logic el);
    int lat;
    mode = m; data_in = d; shift_amt = a; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; data_in = 8'($urandom); shift_amt = 3'($urandom); mode = 2'($urandom);
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); @(negedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, 32'(data_out), 32'(ed));
    chk({tag, "_lost"}, 32'(out_lost), 32'(el));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; data_in = 8'h00; shift_amt = 3'd0; mode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_lost", 32'(out_lost), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_one("shl_81_1", 2'd0, 8'h81, 3'd1, 8'h02, 1'b1);
    run_one("sra_80_3", 2'd2, 8'h80, 3'd3, 8'hF0, 1'b0);
    run_one("shr_f0_4", 2'd1, 8'hF0, 3'd4, 8'h0F, 1'b0);
    run_one("shr_f0_7", 2'd1, 8'hF0, 3'd7, 8'h01, 1'b1);
    run_one("rol_81_4", 2'd3, 8'h81, 3'd4, 8'h18, 1'b0);
    run_one("shl_a5_0", 2'd0, 8'hA5, 3'd0, 8'hA5, 1'b0);
    run_one("shr_a5_0", 2'd1, 8'hA5, 3'd0, 8'hA5, 1'b0);
    run_one("sra_a5_0", 2'd2, 8'hA5, 3'd0, 8'hA5, 1'b0);
    run_one("rol_a5_0", 2'd3, 8'hA5, 3'd0, 8'hA5, 1'b0);
    run_one("shl_80_7", 2'd0, 8'h80, 3'd7, 8'h00, 1'b1);
    run_one("sra_7f_7", 2'd2, 8'h7F, 3'd7, 8'h00, 1'b1);
    run_one("rol_01_7", 2'd3, 8'h01, 3'd7, 8'h80, 1'b0);

    // Backpressure: three SHL-by-1 ops queue up behind a stalled consumer.
    stalled = 1'b0; exp_q.delete();
    out_ready = 1'b0; mode = 2'd0; shift_amt = 3'd1; in_valid = 1'b1;
    data_in = 8'h01; cyc();
    data_in = 8'h02; cyc();
    data_in = 8'h03; cyc();
    in_valid = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(data_out), 32'h02);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1; popped = 0;
    repeat (6) cyc();
    chk("bp_count", 32'(popped), 32'd3);
    chk("bp_empty", 32'(exp_q.size()), 32'd0);

    // Random stream with random backpressure.
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_in   = 8'($urandom);
      shift_amt = 3'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    chk("rand_count", 32'(n_acc >= 1000), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight.
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'd3;
    repeat (3) begin
      data_in = 8'($urandom | 32'h1); shift_amt = 3'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_lost", 32'(out_lost), 32'd0);
    exp_q.delete(); stalled = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_quiet", 32'(out_valid), 32'd0);
    run_one("post_rst_shl", 2'd0, 8'h0F, 3'd2, 8'h3C, 1'b0);
    run_one("post_rst_sra", 2'd2, 8'hC3, 3'd1, 8'hE1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
